// File: rtl/tnn_pkg.sv
// Shared definitions for the line-buffer controller slice: FSM state
// encoding, default frame geometry and a width helper for counters.
package tnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } ctrl_state_e;

    localparam int DEF_KERNEL_SIZE = 5;
    localparam int DEF_IMG_WIDTH   = 32;
    localparam int DEF_IMG_HEIGHT  = 32;

    // Counter width for a range of v values; never narrower than one bit.
    function automatic int clog2w(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/line_buffer_ctrl_raster_counter.sv
// raster_counter: row-major column/row position counter.
// Column wraps WIDTH-1 -> 0 and bumps the row; the row saturates at
// HEIGHT-1 so it never wraps inside a frame. last_o flags the final pixel.
module raster_counter
    import tnn_pkg::*;
#(
    parameter int WIDTH  = DEF_IMG_WIDTH,
    parameter int HEIGHT = DEF_IMG_HEIGHT,
    parameter int COL_W  = clog2w(WIDTH),
    parameter int ROW_W  = clog2w(HEIGHT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             adv_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             last_o
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             col_wrap;
    logic             row_last;

    assign col_wrap = (col_q == COL_W'(WIDTH - 1));
    assign row_last = (row_q == ROW_W'(HEIGHT - 1));

    // Next position: clear wins, otherwise step one pixel in raster order.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (adv_i) begin
            if (col_wrap) begin
                col_d = '0;
                if (!row_last) begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign last_o = col_wrap & row_last;

endmodule

// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: sequences a row-major pixel stream into a line buffer,
// drives its shift enable and flags valid columns / complete windows.
// Optional window stride is compiled in with LINE_BUFFER_CTRL_STRIDE_EN.
//
// Handshake: a pixel moves when pix_valid & pix_ready in the same cycle;
// pix_ready is high only in ACTIVE while downstream asserts out_ready, and
// lb_enable / col_valid / win_valid are only ever high on such a cycle.
module line_buffer_ctrl
    import tnn_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
    parameter int COL_W       = clog2w(IMG_WIDTH),
    parameter int ROW_W       = clog2w(IMG_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef LINE_BUFFER_CTRL_STRIDE_EN
    input  logic [1:0]       stride,
`endif
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic             out_ready,
    output logic             lb_enable,
    output logic             col_valid,
    output logic             win_valid,
    output logic [ROW_W-1:0] win_row,
    output logic [COL_W-1:0] win_col,
    output logic             busy,
    output logic             frame_done
);

    // Reject geometries the line buffer cannot support at elaboration time.
    if (DATA_WIDTH < 1 || KERNEL_SIZE < 2 || KERNEL_SIZE > IMG_WIDTH ||
        IMG_HEIGHT < KERNEL_SIZE) begin : g_bad_params
        $error("line_buffer_ctrl: illegal parameter combination");
    end

    ctrl_state_e      state_q;
    logic             busy_q;
    logic             frame_done_q;
    logic             accept;
    logic             start_frame;
    logic             last_pix;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             row_ok;
    logic             col_ok;
    logic             phase_ok;

    assign start_frame = (state_q == ST_IDLE) & start;
    assign pix_ready   = (state_q == ST_ACTIVE) & out_ready;
    assign accept      = pix_valid & pix_ready;

    raster_counter #(
        .WIDTH  (IMG_WIDTH),
        .HEIGHT (IMG_HEIGHT),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .clear_i (start_frame),
        .adv_i   (accept),
        .col_o   (col),
        .row_o   (row),
        .last_o  (last_pix)
    );

    // Frame sequencing with registered busy / frame_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    frame_done_q <= 1'b0;
                    if (start) begin
                        state_q <= ST_ACTIVE;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (accept && last_pix) begin
                        state_q      <= ST_DONE;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q      <= ST_IDLE;
                    frame_done_q <= 1'b0;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign row_ok = (row >= ROW_W'(KERNEL_SIZE - 1));
    assign col_ok = (col >= COL_W'(KERNEL_SIZE - 1));

`ifdef LINE_BUFFER_CTRL_STRIDE_EN
    logic [1:0] stride_q, stride_d;
    logic [1:0] col_ph_q, col_ph_d;
    logic [1:0] row_ph_q, row_ph_d;
    logic       col_wrap;

    assign col_wrap = (col == COL_W'(IMG_WIDTH - 1));

    // Phases track the next pixel's offset from the first window position,
    // modulo the stride latched at frame start (0 behaves as 1).
    always_comb begin
        stride_d = stride_q;
        col_ph_d = col_ph_q;
        row_ph_d = row_ph_q;
        if (start_frame) begin
            stride_d = (stride == 2'd0) ? 2'd1 : stride;
            col_ph_d = 2'd0;
            row_ph_d = 2'd0;
        end else if (accept) begin
            if (col_wrap || !col_ok) begin
                col_ph_d = 2'd0;
            end else begin
                col_ph_d = (col_ph_q == stride_q - 2'd1) ? 2'd0 : col_ph_q + 2'd1;
            end
            if (col_wrap) begin
                if (!row_ok) begin
                    row_ph_d = 2'd0;
                end else begin
                    row_ph_d = (row_ph_q == stride_q - 2'd1) ? 2'd0 : row_ph_q + 2'd1;
                end
            end
        end
    end

    // Stride and phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stride_q <= 2'd1;
            col_ph_q <= 2'd0;
            row_ph_q <= 2'd0;
        end else begin
            stride_q <= stride_d;
            col_ph_q <= col_ph_d;
            row_ph_q <= row_ph_d;
        end
    end

    assign phase_ok = (col_ph_q == 2'd0) & (row_ph_q == 2'd0);
`else
    assign phase_ok = 1'b1;
`endif

    assign lb_enable  = accept;
    assign col_valid  = accept & row_ok;
    assign win_valid  = col_valid & col_ok & phase_ok;
    assign win_row    = row;
    assign win_col    = col;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
- Sequences a raster pixel stream (row-major) into the `line_buffer` datapath and drives its `enable`.
- Tracks column and row counters and flags when the buffer's `data_out` column is valid and when a full KERNEL_SIZE x KERNEL_SIZE window is available.
- Sits between the pixel source (valid/ready) and the window register/convolution engine; one instance per line buffer.

Parameters:
- DATA_WIDTH, 32, pixel width; passed through for documentation and top-level consistency only.
- KERNEL_SIZE, 5, window edge; must match the line buffer; legal range 2..IMG_WIDTH.
- IMG_WIDTH, 32, pixels per row; must equal the shift_ram depth.
- IMG_HEIGHT, 32, rows per frame; legal range >= KERNEL_SIZE.
- COL_W, $clog2(IMG_WIDTH), column counter width.
- ROW_W, $clog2(IMG_HEIGHT), row counter width.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled in IDLE only.
- pix_valid  in  1  source has a pixel.
- pix_ready  out  1  controller accepts the pixel.
- out_ready  in  1  downstream can take a column/window this cycle.
- lb_enable  out  1  to line_buffer `enable`; high = shift one pixel.
- col_valid  out  1  line_buffer `data_out` holds KERNEL_SIZE valid vertical pixels this cycle.
- win_valid  out  1  downstream window register completes a full window with this column.
- win_row  out  ROW_W  row index of the current pixel (window bottom row).
- win_col  out  COL_W  column index of the current pixel (window right column).
- busy  out  1  high in ACTIVE.
- frame_done  out  1  one-cycle pulse after the last pixel of the frame.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- FSM states: IDLE, ACTIVE, DONE.
  - IDLE -> ACTIVE on `start`. Counters are cleared on this transition.
  - ACTIVE -> DONE when a pixel is accepted at row = IMG_HEIGHT-1, col = IMG_WIDTH-1.
  - DONE -> IDLE unconditionally after one cycle.
- Handshake:
  - pix_ready = (state == ACTIVE) & out_ready. This is combinational from registered state and the input.
  - accept = pix_valid & pix_ready.
  - lb_enable = accept. No other source drives the shift.
- Counters update on accept only:
  - col increments and wraps IMG_WIDTH-1 -> 0.
  - On wrap, row increments. Row does not wrap inside a frame.
- Outputs during an accept cycle (combinational from registered counters; they refer to the pixel currently on data_in):
  - col_valid = accept & (row >= KERNEL_SIZE-1).
  - win_valid = col_valid & (col >= KERNEL_SIZE-1).
  - win_row = row and win_col = col. Both are registered counter values, so they hold between accepts.
- Latency: zero cycles from accept to col_valid/win_valid. The line buffer top row is data_in; lower rows are shift_ram outputs, already valid before the edge.
- frame_done: registered, high exactly in the DONE cycle.
- busy: high in ACTIVE only.
- Stall: pix_valid=0 or out_ready=0 freezes counters. lb_enable, col_valid and win_valid are all 0 that cycle.
- start while ACTIVE or DONE: ignored.
- Reset values, including reset mid-frame:
  - state = IDLE; col = 0; row = 0; frame_done = 0.
  - All combinational outputs are 0.
  - Shift_ram contents are not cleared. The rows of the next frame are gated by the row counter, so stale data never reaches win_valid.
- Windows per frame: (IMG_HEIGHT-KERNEL_SIZE+1) x (IMG_WIDTH-KERNEL_SIZE+1).

Optional Feature:
- Macro: LINE_BUFFER_CTRL_STRIDE_EN.
- When defined:
  - Adds input `stride`, 2 bits, values 1..3. It is latched on the IDLE->ACTIVE transition; value 0 is treated as 1.
  - Adds row-phase and column-phase counters. Each resets to 0 when its index reaches KERNEL_SIZE-1 and increments modulo the latched stride after that.
  - win_valid additionally requires both phases == 0.
  - col_valid and lb_enable are unchanged.
- When undefined: no `stride` port; stride is fixed at 1.

Decomposition:
- Shared package `tnn_pkg`:
  - FSM state enum (IDLE/ACTIVE/DONE).
  - Default KERNEL_SIZE, IMG_WIDTH and IMG_HEIGHT constants.
  - A clog2 width helper.
- One natural sub-module: `raster_counter`, the column/row counter with wrap and last-pixel flag. It is reusable by the output-side writer.

Test Plan:
- Reset: K=5, W=8, H=6; hold rst 3 cycles -> all outputs 0, state IDLE; start pulse -> busy=1 next cycle.
- Full frame, pix_valid=1, out_ready=1 -> 48 lb_enable pulses; col_valid count 16; first win_valid on the 37th accept (row 4, col 4); 8 win_valid total; frame_done exactly 1 cycle after the 48th accept.
- Backpressure: out_ready toggles 1/0 every cycle -> pix_ready tracks out_ready; no lb_enable while out_ready=0; still 8 windows, with counters identical to the unstalled run.
- Reset mid-frame: rst at accept #20, then start -> row=0, col=0; the new frame yields exactly 8 windows; no win_valid before row 4.
- start while busy -> ignored; no counter clear; frame_done count 1.
- LINE_BUFFER_CTRL_STRIDE_EN with stride=2 -> win_valid at (4,4) and (4,6) only, 2 windows; stride=0 -> 8 windows.
